// File: rtl/seq_scan_ctrl.sv
// Serial pattern scanner: each accepted word is shifted out MSB first and checked for a
// programmable 3-bit pattern over a continuous bit stream, with per-word and running totals.
module seq_scan_ctrl #(
    parameter int unsigned WORD_W = 8,
    parameter int unsigned WCNT_W = 4,
    parameter int unsigned TCNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic              pat_load,
    input  logic [2:0]        pattern,
    output logic              bit_out,
    output logic              bit_valid,
    output logic              tick,
    output logic              busy,
    output logic              word_done,
    output logic [WCNT_W-1:0] word_count,
    output logic [TCNT_W-1:0] total_count
);

    localparam int unsigned BCNT_W = $clog2(WORD_W);

    typedef enum logic [1:0] {IDLE, SHIFT, REPORT} state_t;

    state_t            r_state;
    logic [WORD_W-1:0] r_shift;
    logic [BCNT_W-1:0] r_bcnt;
    logic [2:0]        r_pat;
    logic [1:0]        r_hist;
    logic [1:0]        r_fill;
    logic [WCNT_W-1:0] r_wcnt;
    logic [WCNT_W-1:0] r_word_count;
    logic [TCNT_W-1:0] r_total;
    logic              r_tick;
    logic              r_done;

    logic              w_bit;
    logic              w_match;
    logic              w_last;
    logic [WCNT_W-1:0] w_wcnt_next;

    assign w_bit       = r_shift[WORD_W-1];
    // Only a full 3-bit window may match; fill is cleared by reset and pattern reloads.
    assign w_match     = (r_state == SHIFT) && (r_fill == 2'd2) && ({r_hist, w_bit} == r_pat);
    assign w_last      = (r_bcnt == '0);
    assign w_wcnt_next = w_match ? r_wcnt + WCNT_W'(1) : r_wcnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_shift      <= '0;
            r_bcnt       <= '0;
            r_pat        <= 3'b101;
            r_hist       <= 2'b00;
            r_fill       <= 2'd0;
            r_wcnt       <= '0;
            r_word_count <= '0;
            r_total      <= '0;
            r_tick       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_tick <= w_match;
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (pat_load) begin
                        r_pat  <= pattern;
                        r_fill <= 2'd0;
                    end
                    if (in_valid) begin
                        r_shift <= in_data;
                        r_bcnt  <= BCNT_W'(WORD_W - 1);
                        r_wcnt  <= '0;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_shift <= {r_shift[WORD_W-2:0], 1'b0};
                    r_hist  <= {r_hist[0], w_bit};
                    if (r_fill != 2'd2) begin
                        r_fill <= r_fill + 2'd1;
                    end
                    r_wcnt <= w_wcnt_next;
                    if (w_match && !(&r_total)) begin
                        r_total <= r_total + TCNT_W'(1);
                    end
                    if (w_last) begin
                        r_state      <= REPORT;
                        r_done       <= 1'b1;
                        r_word_count <= w_wcnt_next;
                    end else begin
                        r_bcnt <= r_bcnt - BCNT_W'(1);
                    end
                end
                REPORT: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready    = (r_state == IDLE);
    assign busy        = (r_state != IDLE);
    assign bit_valid   = (r_state == SHIFT);
    assign bit_out     = w_bit;
    assign tick        = r_tick;
    assign word_done   = r_done;
    assign word_count  = r_word_count;
    assign total_count = r_total;

endmodule

// File: doc/seq_scan_ctrl.md
SEQ_SCAN_CTRL -- requirements
Module: seq_scan_ctrl

Interface
REQ-001 The block SHALL have one clock and one reset; reset is asynchronous and active-high; the clock port is clk and the reset port is rst.
REQ-002 Parameters (name, default, meaning):
  WORD_W, 8, bits per input word (>=3).
  WCNT_W, 4, width of per-word match count (>= clog2(WORD_W+1)).
  TCNT_W, 16, width of running total match count.
REQ-003 Ports (name, direction, width, meaning):
  clk          in   1        clock, rising edge
  rst          in   1        async active-high reset
  in_valid     in   1        input word offered
  in_ready     out  1        block accepts word this cycle
  in_data      in   WORD_W   word to scan, MSB first
  pat_load     in   1        load new 3-bit target pattern
  pattern      in   3        target pattern, pattern[2] oldest bit
  bit_out      out  1        serial bit currently being scanned
  bit_valid    out  1        bit_out meaningful this cycle
  tick         out  1        registered match pulse
  busy         out  1        word in progress (not IDLE)
  word_done    out  1        one-cycle pulse, word_count valid
  word_count   out  WCNT_W   matches found in last completed word
  total_count  out  TCNT_W   saturating running total of matches

Function
REQ-004 FSM states SHALL be IDLE, SHIFT, REPORT; transitions: IDLE->SHIFT on in_valid&in_ready; SHIFT->REPORT after WORD_W bits; REPORT->IDLE unconditionally.
REQ-005 in_ready SHALL be 1 only in IDLE; in_valid outside IDLE SHALL be ignored and in_data not sampled.
REQ-006 On accept, in_data SHALL load a shift register, bit counter set to WORD_W-1, word match counter cleared.
REQ-007 In SHIFT, bit_out SHALL equal shift-register MSB and bit_valid=1; shift register shifts left once per cycle; bit_valid=0 in IDLE and REPORT.
REQ-008 A 2-bit history plus a fill counter (0..2) SHALL track previously scanned bits; history SHALL persist across words (continuous stream, no clear between words).
REQ-009 A match SHALL occur in a SHIFT cycle when fill counter==2 and {history,bit_out}==pattern register; overlapping matches SHALL be counted.
REQ-010 On the clock edge ending a matching SHIFT cycle, tick SHALL be set for exactly one cycle, word match counter +1, total_count +1 saturating at all-ones.
REQ-011 History update each SHIFT cycle: history<={history[0],bit_out}; fill counter increments to max 2.
REQ-012 REPORT SHALL last exactly one cycle with word_done=1; word_count SHALL update at entry to REPORT (including a match on the last bit) and hold until next REPORT.
REQ-013 Latency: word accepted at edge N; bits scanned cycles N+1..N+WORD_W; word_done at cycle N+WORD_W+1; next accept earliest edge N+WORD_W+2.
REQ-014 pat_load SHALL be honoured only in IDLE (including the same cycle as an accept, new pattern applies to that word) and SHALL clear fill counter; pat_load in SHIFT/REPORT SHALL be ignored.
REQ-015 busy SHALL be 1 in SHIFT and REPORT, 0 in IDLE.

Reset
REQ-016 While rst=1, state=IDLE, pattern register=3'b101, history=0, fill=0, shift register=0, tick=0, word_done=0, word_count=0, total_count=0, bit_valid=0, in_ready=1 after release.
REQ-017 Reset asserted mid-SHIFT SHALL abort the word immediately; no word_done for the aborted word.

Verification
REQ-018 Reset, default pattern, word 8'b10101000 -> tick after bit indices 2 and 4, word_done 9 cycles after accept, word_count=2, total_count=2.
REQ-019 Word 8'b00000010 then 8'b10000000 -> word_count=0 then 1 (match spans word boundary), total_count=1.
REQ-020 pat_load with 3'b111 in IDLE, word 8'hFF -> word_count=6; then 8'hFF again -> word_count=8 (history carried), total_count=14.
REQ-021 pat_load 3'b000 asserted during SHIFT, word 8'h00 -> pattern stays 101, word_count=0; in_valid held during busy -> in_ready=0, no second word accepted until IDLE.
REQ-022 rst pulsed at 4th SHIFT cycle of word 8'hAA -> all outputs zero, no word_done, next word 8'b10100000 scans from empty history -> word_count=1.
REQ-023 Preload total_count near max (TCNT_W=4 build), feed 8'hAA words with 101 -> total_count saturates at 4'hF, word_count still correct.
